aes_key_expand: RTL
===================

# aes_key_expand

Sequential AES-128 key-schedule unit that expands a 128-bit cipher key into the 44-word round-key schedule. It sits directly upstream of the AddRoundKey stage. It stores the schedule internally and serves any round-key column as four bytes, in the same per-cell form the AddRoundKey column B inputs consume. It publishes how many complete round keys are ready, so round 0 can start before expansion finishes.

## Interface
Parameters:
- NR, 10, number of rounds; schedule depth is 4*(NR+1) = 44 words. Only 10 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to load key_in and expand; ignored while busy
- key_in  in  128  cipher key; key_in[127:120] is key byte 0
- busy  out  1  expansion in progress
- ready  out  1  full schedule (11 round keys) valid
- rounds_avail  out  4  count of complete round keys stored, 0..11
- rd_round  in  4  round-key index to read, 0..10
- rd_col  in  2  column (word) within that round key
- rk_col0..rk_col3  out  8 each  bytes 0..3 of word w[4*rd_round+rd_col]; rk_col0 is the word's MSB

## Operation
- FSM states: IDLE, EXPAND, DONE.
  - IDLE/DONE with start=1 at edge T0: write w0..w3 from key_in, set idx=4, rounds_avail=1, go to EXPAND.
  - EXPAND: at each edge compute and write w[idx], then idx++.
  - When idx=43 is written (edge T40), go to DONE.
- Word rule for idx ≥ 4: w[i] = w[i-4] ^ t.
  - If i%4==0: t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/4],24'h0}.
  - Otherwise: t = w[i-1].
  - RotWord is a left byte rotation. Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- rounds_avail becomes r+1 at the edge writing w[4r+3], i.e. edge T(4r).
- Outputs:
  - busy = (state==EXPAND).
  - ready = (state==DONE).
  - rk_col* return the selected word if rd_round < rounds_avail; otherwise they return 0, including rd_round > 10.
- start during EXPAND: ignored entirely; no restart, no effect on idx.
- start in DONE: restarts. rounds_avail drops to 1 at T0 and old rounds ≥1 become unreadable.
- Reset (any state, including mid-EXPAND):
  - state=IDLE, idx=0, rounds_avail=0, busy=0, ready=0, rk_col*=0.
  - Storage contents are not cleared; they are masked by rounds_avail.

## Timing
- start→busy: busy high the cycle after T0 through the cycle of T40. ready high from the cycle after T40.
- Expansion latency: 41 edges (T0..T40). Round r is readable from the cycle after T(4r).
- Read port latency: combinational (0 cycles) by default; see Configuration.
- Throughput: one schedule word per cycle; one SubWord (4 S-box lookups) per cycle.

## Configuration
- AES_KEY_READ_REG_EN defined:
  - rk_col0..3 are registered, with 1-cycle latency from rd_round/rd_col.
  - The rounds_avail mask is evaluated at the sample edge.
  - Output registers reset to 0.
- Undefined: the read port is purely combinational from storage.

## Structure
- Shared package aes_pkg holds:
  - constants NK=4, NR=10, NW=44;
  - typedef word_t (logic [31:0]);
  - RCON table;
  - FSM state enum.
- Sub-module aes_sbox: a combinational 8-bit forward S-box, instantiated four times for SubWord. The same module is reused by the SubBytes stage.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start:
  - w4 reads a0fafe17;
  - round 10 columns read d014f9a8, c9ee2589, e13f0cc8, b6630ca6;
  - ready asserts exactly 41 edges after start.
- All-zero key:
  - round 1 columns all read 62636363;
  - rounds_avail steps 1,2,…,11 at edges T0,T4,…,T40.
- Read round 5 while rounds_avail=3 → rk_col*=00.
- Read rd_round=12 after ready → 00.
- Pulse start with a different key at T10 during EXPAND → ignored; final schedule matches the first key.
- Assert rst at T20 → busy, ready, rounds_avail and rk_col* go to 0 immediately.
- After rst, start with the FIPS key → correct full schedule.
- With AES_KEY_READ_REG_EN: change rd_round 0→10 after ready → rk_col* update one cycle later with the round-10 word.

Source files
------------

// File: rtl/aes_key_expand_pkg.sv
// Shared AES definitions: schedule constants, word type, round constants, key-expansion FSM states.
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;
  localparam int NW = 4 * (NR + 1);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  // Rcon[1..10]; indices outside that range never reach the SubWord path.
  function automatic logic [7:0] get_rcon(input logic [3:0] i_round);
    logic [7:0] v;
    case (i_round)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Control and round-key read bus of the AES-128 key-schedule unit.
interface aes_key_expand_if;

  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         ready;
  logic [3:0]   rounds_avail;
  logic [3:0]   rd_round;
  logic [1:0]   rd_col;
  logic [7:0]   rk_col0;
  logic [7:0]   rk_col1;
  logic [7:0]   rk_col2;
  logic [7:0]   rk_col3;

  modport master (
    output start, key_in, rd_round, rd_col,
    input  busy, ready, rounds_avail, rk_col0, rk_col1, rk_col2, rk_col3
  );

  modport slave (
    input  start, key_in, rd_round, rd_col,
    output busy, ready, rounds_avail, rk_col0, rk_col1, rk_col2, rk_col3
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) multiplicative inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // x^254 is the inverse for x != 0 and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = gf_mul(x, x);
    for (int k = 1; k < 8; k++) begin
      r    = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one word per cycle into local storage, round keys readable as they complete.
// Optional macro AES_KEY_READ_REG_EN registers the round-key read port (1-cycle latency).
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  if_kx
);

  import aes_pkg::*;

  localparam int NWL = 4 * (NR + 1);

  state_t     r_state, w_state_next;
  logic [5:0] r_idx, w_idx_next;
  logic [3:0] r_avail, w_avail_next;
  word_t      r_win [4];
  word_t      w_win_next [4];
  word_t      r_mem [NWL];
  word_t      w_key_word [4];
  word_t      w_rot, w_sub, w_temp, w_new;
  logic       w_load, w_step;
  logic [5:0] w_rd_addr;
  logic       w_rd_ok;
  word_t      w_rd_word;

  // r_win holds w[idx-4..idx-1] so the next word never needs a storage read.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign w_key_word[gi] = if_kx.key_in[127 - 32*gi -: 32];
      aes_sbox u_sbox (
        .i_byte (w_rot[8*gi +: 8]),
        .o_byte (w_sub[8*gi +: 8])
      );
    end
  endgenerate

  assign w_rot  = {r_win[3][23:0], r_win[3][31:24]};
  assign w_temp = (r_idx[1:0] == 2'd0) ? (w_sub ^ {get_rcon(r_idx[5:2]), 24'h0}) : r_win[3];
  assign w_new  = r_win[0] ^ w_temp;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_avail_next = r_avail;
    w_load       = 1'b0;
    w_step       = 1'b0;
    for (int i = 0; i < 4; i++) w_win_next[i] = r_win[i];

    case (r_state)
      IDLE, DONE: begin
        if (if_kx.start) begin
          w_load       = 1'b1;
          w_state_next = EXPAND;
          w_idx_next   = 6'd4;
          w_avail_next = 4'd1;
          for (int i = 0; i < 4; i++) w_win_next[i] = w_key_word[i];
        end
      end
      EXPAND: begin
        w_step        = 1'b1;
        w_idx_next    = r_idx + 6'd1;
        w_win_next[0] = r_win[1];
        w_win_next[1] = r_win[2];
        w_win_next[2] = r_win[3];
        w_win_next[3] = w_new;
        if (r_idx[1:0] == 2'd3) w_avail_next = r_avail + 4'd1;
        if (r_idx == 6'(NWL - 1)) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 6'd0;
      r_avail <= 4'd0;
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_avail <= w_avail_next;
      for (int i = 0; i < 4; i++) r_win[i] <= w_win_next[i];
    end
  end

  // Storage is never cleared; stale words stay hidden behind rounds_avail.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= w_key_word[i];
    end else if (w_step) begin
      r_mem[r_idx] <= w_new;
    end
  end

  assign w_rd_addr = {if_kx.rd_round, if_kx.rd_col};
  assign w_rd_ok   = (if_kx.rd_round < r_avail);
  assign w_rd_word = w_rd_ok ? r_mem[w_rd_addr] : '0;

`ifdef AES_KEY_READ_REG_EN
  word_t r_rk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rk <= '0;
    else     r_rk <= w_rd_word;
  end

  assign {if_kx.rk_col0, if_kx.rk_col1, if_kx.rk_col2, if_kx.rk_col3} = r_rk;
`else
  assign {if_kx.rk_col0, if_kx.rk_col1, if_kx.rk_col2, if_kx.rk_col3} = w_rd_word;
`endif

  assign if_kx.busy         = (r_state == EXPAND);
  assign if_kx.ready        = (r_state == DONE);
  assign if_kx.rounds_avail = r_avail;

endmodule
